// File: rtl/seq_mult_arbiter.sv
// Round-robin arbiter in front of one shared signed shift-add sequential multiplier.
// Define EARLY_TERM_EN to finish a multiply as soon as the remaining multiplier bits are all zero.
module seq_mult_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 32,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic [NUM_REQ*WIDTH-1:0]   req_a,
  input  logic [NUM_REQ*WIDTH-1:0]   req_b,
  output logic                       resp_valid,
  input  logic                       resp_ready,
  output logic [ID_W-1:0]            resp_id,
  output logic [2*WIDTH-1:0]         resp_product,
  output logic                       busy
);

  localparam int PW    = 2 * WIDTH;
  localparam int CNT_W = $clog2(PW);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state_q;
  logic [ID_W-1:0]   rr_ptr_q;
  logic [CNT_W-1:0]  count_q;
  logic [PW-1:0]     acc_q;
  logic [PW-1:0]     b_q;
  logic [PW-1:0]     q_q;
  logic              resp_valid_q;
  logic [ID_W-1:0]   resp_id_q;
  logic [PW-1:0]     resp_product_q;
  logic              busy_q;

  // Candidate k is the requester k positions past the round-robin pointer, wrapping at NUM_REQ.
  logic [ID_W-1:0]   cand_idx [NUM_REQ];
  logic [WIDTH-1:0]  a_arr    [NUM_REQ];
  logic [WIDTH-1:0]  b_arr    [NUM_REQ];

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
    logic [ID_W:0] sum;
    assign sum          = {1'b0, rr_ptr_q} + (ID_W+1)'(gi);
    assign cand_idx[gi] = (sum >= (ID_W+1)'(NUM_REQ)) ? ID_W'(sum - (ID_W+1)'(NUM_REQ))
                                                       : sum[ID_W-1:0];
    assign a_arr[gi]    = req_a[gi*WIDTH +: WIDTH];
    assign b_arr[gi]    = req_b[gi*WIDTH +: WIDTH];
  end

  logic [ID_W-1:0] grant;
  logic            grant_found;

  // Walk from the farthest candidate back so the nearest valid one wins.
  always_comb begin
    grant       = '0;
    grant_found = 1'b0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req_valid[cand_idx[k]]) begin
        grant       = cand_idx[k];
        grant_found = 1'b1;
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (state_q == IDLE && grant_found) begin
      req_ready[grant] = 1'b1;
    end
  end

  logic [WIDTH-1:0] a_sel;
  logic [WIDTH-1:0] b_sel;
  assign a_sel = a_arr[grant];
  assign b_sel = b_arr[grant];

  logic [PW-1:0]    acc_d;
  logic [PW-1:0]    b_d;
  logic [PW-1:0]    q_d;
  logic [CNT_W-1:0] count_d;
  logic             run_last;
  logic [ID_W-1:0]  rr_ptr_d;

  assign acc_d   = acc_q + (q_q[0] ? b_q : '0);
  assign b_d     = b_q << 1;
  assign q_d     = $signed(q_q) >>> 1;
  assign count_d = count_q + CNT_W'(1);

`ifdef EARLY_TERM_EN
  // Once the arithmetic shift leaves zero, every remaining partial product is zero.
  assign run_last = (count_q == CNT_W'(PW - 1)) || (q_d == '0);
`else
  assign run_last = (count_q == CNT_W'(PW - 1));
`endif

  assign rr_ptr_d = (resp_id_q == ID_W'(NUM_REQ - 1)) ? '0 : resp_id_q + ID_W'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      rr_ptr_q       <= '0;
      count_q        <= '0;
      acc_q          <= '0;
      b_q            <= '0;
      q_q            <= '0;
      resp_valid_q   <= 1'b0;
      resp_id_q      <= '0;
      resp_product_q <= '0;
      busy_q         <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (grant_found) begin
            b_q       <= {{WIDTH{a_sel[WIDTH-1]}}, a_sel};
            q_q       <= {{WIDTH{b_sel[WIDTH-1]}}, b_sel};
            acc_q     <= '0;
            count_q   <= '0;
            resp_id_q <= grant;
            busy_q    <= 1'b1;
            state_q   <= RUN;
          end
        end
        RUN: begin
          acc_q   <= acc_d;
          b_q     <= b_d;
          q_q     <= q_d;
          count_q <= count_d;
          if (run_last) begin
            resp_product_q <= acc_d;
            resp_valid_q   <= 1'b1;
            state_q        <= DONE;
          end
        end
        DONE: begin
          if (resp_ready) begin
            resp_valid_q <= 1'b0;
            rr_ptr_q     <= rr_ptr_d;
            busy_q       <= 1'b0;
            state_q      <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign resp_valid   = resp_valid_q;
  assign resp_id      = resp_id_q;
  assign resp_product = resp_product_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_seq_mult_arbiter.sv
// Randomized scoreboard bench for seq_mult_arbiter; build with EARLY_TERM_EN to match that RTL build.
module tb_seq_mult_arbiter;

  localparam int N  = 4;
  localparam int W  = 32;
  localparam int IW = $clog2(N);

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic [N-1:0]       req_ready;
  logic [N*W-1:0]     req_a;
  logic [N*W-1:0]     req_b;
  logic               resp_valid;
  logic               resp_ready = 1'b1;
  logic [IW-1:0]      resp_id;
  logic [2*W-1:0]     resp_product;
  logic               busy;

  logic [N-1:0]       v = '0;
  logic [W-1:0]       oa [N];
  logic [W-1:0]       ob [N];
  logic [N-1:0]       acc_flag = '0;
  int                 rnd_mode = 0;
  int                 rr_mode  = 0;

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;

  typedef struct {
    int          id;
    logic [63:0] prod;
  } exp_t;
  exp_t sb[$];

  int          m_idle  = 1;
  int          m_rr    = 0;
  int          m_ready = 0;
  int          m_id    = 0;
  int          have_cur = 0;
  exp_t        cur;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  always_comb begin
    for (int i = 0; i < N; i++) begin
      req_a[i*W +: W] = oa[i];
      req_b[i*W +: W] = ob[i];
    end
  end

  seq_mult_arbiter #(.NUM_REQ(N), .WIDTH(W)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (v),
    .req_ready    (req_ready),
    .req_a        (req_a),
    .req_b        (req_b),
    .resp_valid   (resp_valid),
    .resp_ready   (resp_ready),
    .resp_id      (resp_id),
    .resp_product (resp_product),
    .busy         (busy)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [63:0] ref_prod(input logic [W-1:0] a, input logic [W-1:0] b);
    longint x;
    longint y;
    x = longint'($signed(a));
    y = longint'($signed(b));
    return x * y;
  endfunction

  function automatic int ref_lat(input logic [W-1:0] b);
`ifdef EARLY_TERM_EN
    longint bb;
    int m;
    bb = longint'($signed(b));
    if (bb < 0) return 2 * W;
    if (bb == 0) return 1;
    m = 0;
    while ((bb >> m) != 0) m++;
    return m;
`else
    return 2 * W;
`endif
  endfunction

  function automatic logic [W-1:0] rand_word();
    case ($urandom_range(0, 5))
      0:       return 32'h8000_0000;
      1:       return 32'h7FFF_FFFF;
      2:       return W'($urandom_range(0, 20));
      3:       return -W'($urandom_range(0, 20));
      default: return W'($urandom);
    endcase
  endfunction

  // Reference model: round-robin pick among the bench's own valid flags, fixed timing per operation.
  always @(negedge clk) begin
    if (rst) begin
      m_idle = 1;
      m_rr   = 0;
      sb.delete();
    end else if (m_idle != 0) begin
      int g;
      logic [N-1:0] exp_rdy;
      g = -1;
      for (int k = 0; k < N; k++) begin
        if (g < 0 && v[(m_rr + k) % N]) g = (m_rr + k) % N;
      end
      exp_rdy = '0;
      if (g >= 0) exp_rdy[g] = 1'b1;
      chk("req_ready_idle", 64'(req_ready), 64'(exp_rdy));
      chk("busy_idle", 64'(busy), 64'd0);
      chk("resp_valid_idle", 64'(resp_valid), 64'd0);
      if (g >= 0) begin
        exp_t e;
        e.id    = g;
        e.prod  = ref_prod(oa[g], ob[g]);
        sb.push_back(e);
        m_idle  = 0;
        m_id    = g;
        m_ready = cyc + 1 + ref_lat(ob[g]);
        acc_flag[g] = 1'b1;
      end
    end else begin
      chk("req_ready_busy", 64'(req_ready), 64'd0);
      chk("busy_active", 64'(busy), 64'd1);
      chk("resp_valid_timing", 64'(resp_valid), 64'(cyc >= m_ready));
      if (cyc >= m_ready && resp_ready) begin
        m_idle = 1;
        m_rr   = (m_id + 1) % N;
      end
    end
  end

  // Monitor: pops the scoreboard when a response appears, then checks it stays stable until taken.
  always @(negedge clk) begin
    if (rst) begin
      have_cur = 0;
    end else if (resp_valid) begin
      if (have_cur == 0) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_err++;
          $display("FAIL unexpected_resp: got id=%0d product=%h, expected no response", resp_id, resp_product);
        end else begin
          cur = sb.pop_front();
          have_cur = 1;
          chk("resp_id", 64'(resp_id), 64'(cur.id));
          chk("resp_product", resp_product, cur.prod);
          $display("resp id=%0d product=%h expected id=%0d product=%h cycle=%0d",
                   resp_id, resp_product, cur.id, cur.prod, cyc);
        end
      end else begin
        chk("resp_id_stable", 64'(resp_id), 64'(cur.id));
        chk("resp_product_stable", resp_product, cur.prod);
      end
      if (resp_ready) have_cur = 0;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      if (acc_flag[i]) begin
        acc_flag[i] = 1'b0;
        if (rnd_mode != 0) begin
          oa[i] = rand_word();
          ob[i] = rand_word();
          v[i]  = (rnd_mode == 1) ? 1'b1 : 1'($urandom_range(0, 1));
        end else begin
          v[i] = 1'b0;
        end
      end else if (rnd_mode == 2) begin
        if (!v[i] && $urandom_range(0, 7) == 0) begin
          oa[i] = rand_word();
          ob[i] = rand_word();
          v[i]  = 1'b1;
        end else if (v[i] && $urandom_range(0, 31) == 0) begin
          v[i] = 1'b0;
        end
      end
    end
    case (rr_mode)
      0:       resp_ready = 1'b1;
      1:       resp_ready = ($urandom_range(0, 3) != 0);
      default: resp_ready = 1'b0;
    endcase
  endtask

  task automatic issue(input int id, input logic [W-1:0] a, input logic [W-1:0] b);
    oa[id] = a;
    ob[id] = b;
    v[id]  = 1'b1;
  endtask

  task automatic wait_accept(input int id);
    int t;
    t = 0;
    while (v[id] && t < 500) begin
      step();
      t++;
    end
    n_checks++;
    if (v[id]) begin
      n_err++;
      $display("FAIL accept_timeout: requester %0d still pending after %0d cycles, expected grant", id, t);
    end
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (!(m_idle != 0 && sb.size() == 0 && have_cur == 0) && t < 3000) begin
      step();
      t++;
    end
    n_checks++;
    if (t >= 3000) begin
      n_err++;
      $display("FAIL drain_timeout: %0d responses outstanding, expected 0", sb.size());
    end
  endtask

  initial begin
    repeat (40000) @(posedge clk);
    n_err++;
    $display("FAIL watchdog: simulation reached cycle %0d, expected completion earlier", cyc);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    for (int i = 0; i < N; i++) begin
      oa[i] = '0;
      ob[i] = '0;
    end
    #2 rst = 1'b1;
    repeat (3) step();
    @(negedge clk);
    chk("rst_resp_valid", 64'(resp_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_req_ready", 64'(req_ready), 64'd0);
    step();
    rst = 1'b0;

    // Stalled response on req0 while req1 waits; req1 follows the handshake.
    issue(0, 32'd3, -32'sd4);
    issue(1, 32'd11, 32'd13);
    rr_mode = 2;
    wait_accept(0);
    for (int t = 0; t < 200 && !resp_valid; t++) step();
    repeat (10) step();
    rr_mode = 0;
    wait_accept(1);
    drain();

    step(); issue(0, 32'h8000_0000, 32'h8000_0000); wait_accept(0); drain();
    step(); issue(0, 32'h7FFF_FFFF, 32'hFFFF_FFFF); wait_accept(0); drain();
    step(); issue(1, 32'd9, 32'd0);                 wait_accept(1); drain();
    step(); issue(2, 32'd7, 32'd5);                 wait_accept(2); drain();
    step(); issue(3, 32'd3, 32'hFFFF_FFFF);         wait_accept(3); drain();

    // All requesters valid back to back.
    step();
    for (int i = 0; i < N; i++) issue(i, rand_word(), rand_word());
    rnd_mode = 1;
    repeat (5 * 66 + 20) step();

    // Fully random traffic with back-pressure.
    rnd_mode = 2;
    rr_mode  = 1;
    repeat (2500) step();
    rnd_mode = 0;
    rr_mode  = 0;
    v = '0;
    drain();

    // Abort mid-multiply with reset, then a fresh request.
    step(); issue(2, 32'd1234, -32'sd77); wait_accept(2);
    repeat (20) step();
    rst = 1'b1;
    @(negedge clk);
    chk("abort_resp_valid", 64'(resp_valid), 64'd0);
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_req_ready", 64'(req_ready), 64'd0);
    chk("abort_resp_id", 64'(resp_id), 64'd0);
    chk("abort_resp_product", resp_product, 64'd0);
    step();
    rst = 1'b0;
    repeat (3) step();
    issue(2, 32'hFFFF_FF00, 32'd100000); wait_accept(2); drain();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
